// File: rtl/serial_div_pkg.sv
// Shared encodings and helpers for the radix-2 restoring divider.
// State codes, counter sizing and the divide-by-zero quotient.
package serial_div_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_SIGN = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      SIGN = ST_SIGN,
      DONE = ST_DONE
   } state_t;

   // Sliced down to XLEN by the user.
   localparam logic [63:0] DIV0_QUOTIENT = '1;

   function automatic int cnt_w(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

endpackage

// File: rtl/serial_div_if.sv
// Operand/result bundle between the register file and the divider.
// master = register file side, slave = divider core.
interface serial_div_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic            signed_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic            busy_o;
   logic            fini_o;
   logic            dbz_o;
   logic [XLEN-1:0] quotient_o;
   logic [XLEN-1:0] remainder_o;

   modport master (
      output start_i, signed_i, dividend_i, divisor_i,
      input  busy_o, fini_o, dbz_o, quotient_o, remainder_o
   );

   modport slave (
      input  start_i, signed_i, dividend_i, divisor_i,
      output busy_o, fini_o, dbz_o, quotient_o, remainder_o
   );

endinterface

// File: rtl/serial_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the result if non-negative.
module serial_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divs,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0]   w_shift;
   logic [XLEN-1:0] w_sub;
   logic            w_ge;

   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, i_divs});
   // Low bits of the difference are exact whenever w_ge holds.
   assign w_sub   = w_shift[XLEN-1:0] - i_divs;
   assign o_rem   = w_ge ? w_sub : w_shift[XLEN-1:0];
   assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/serial_div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Signed operation divides magnitudes and fixes signs in SIGN.
module serial_div_core
   import serial_div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   serial_div_if.slave bus
);

   localparam int CW = cnt_w(XLEN);

   state_t          r_state;
   state_t          w_state_n;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_divs;
   logic [XLEN-1:0] r_q_out;
   logic [XLEN-1:0] r_r_out;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_dbz;

   logic [XLEN-1:0] w_rem_n;
   logic [XLEN-1:0] w_quo_n;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_a_neg;
   logic            w_b_neg;
   logic            w_div0;
   logic            w_accept;

   assign w_div0  = (bus.divisor_i == '0);
   assign w_a_neg = bus.signed_i & bus.dividend_i[XLEN-1];
   assign w_b_neg = bus.signed_i & bus.divisor_i[XLEN-1];
   assign w_a_mag = w_a_neg ? -bus.dividend_i : bus.dividend_i;
   assign w_b_mag = w_b_neg ? -bus.divisor_i : bus.divisor_i;

   always_comb begin
      w_state_n = r_state;
      w_accept  = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (bus.start_i) begin
               w_accept  = 1'b1;
               w_state_n = w_div0 ? DONE : CALC;
            end else begin
               w_state_n = IDLE;
            end
         end
         CALC: begin
            if (r_cnt == CW'(1)) begin
               w_state_n = SIGN;
            end
         end
         SIGN: begin
            w_state_n = DONE;
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   serial_div_step #(
      .XLEN (XLEN)
   ) u_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_divs (r_divs),
      .o_rem  (w_rem_n),
      .o_quo  (w_quo_n)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_divs  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_q_out <= '0;
         r_r_out <= '0;
         r_dbz   <= 1'b0;
      end else if (w_accept) begin
         if (w_div0) begin
            r_cnt   <= '0;
            r_q_out <= DIV0_QUOTIENT[XLEN-1:0];
            r_r_out <= bus.dividend_i;
            r_dbz   <= 1'b1;
         end else begin
            r_cnt   <= CW'(XLEN);
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_divs  <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
         end
      end else if (r_state == CALC) begin
         r_rem <= w_rem_n;
         r_quo <= w_quo_n;
         r_cnt <= r_cnt - CW'(1);
      end else if (r_state == SIGN) begin
         r_q_out <= r_neg_q ? -r_quo : r_quo;
         r_r_out <= r_neg_r ? -r_rem : r_rem;
         r_dbz   <= 1'b0;
      end
   end

   assign bus.busy_o      = (r_state == CALC) || (r_state == SIGN);
   assign bus.fini_o      = (r_state == DONE);
   assign bus.dbz_o       = r_dbz;
   assign bus.quotient_o  = r_q_out;
   assign bus.remainder_o = r_r_out;

endmodule
